// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and access-size helper for the data memory LSU
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, LOAD, RESP} dmem_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction
endpackage

// File: rtl/dmem_be_ram.sv
// dmem_be_ram: single-port word RAM with per-byte write enables and registered read
module dmem_be_ram #(
  parameter int DATA_W    = 32,
  parameter int AW        = 7,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic [AW-1:0]       i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_en) r_rdata <= r_mem[i_addr];
    for (int b = 0; b < DATA_W/8; b++)
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory with load/store unit and valid/ready handshake
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int AW    = DM_ADDRESS - OFFW;
    localparam int DEPTH = (2**DM_ADDRESS) / NB;
    localparam bit W64   = (DATA_W == 64);

    dmem_state_e           r_state, w_next;
    logic [OFFW-1:0]       r_off;
    logic [2:0]            r_f3;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic                  w_acc, w_legal, w_mis, w_oor, w_err, w_sgn;
    logic [3:0]            w_sz, w_rsz;
    logic [6:0]            w_nb;
    logic [DM_ADDRESS-1:0] w_idx;
    logic [NB-1:0]         w_be;
    logic [DATA_W-1:0]     w_wdata, w_raw, w_lane, w_low, w_top, w_ext;

    // request decode: legality, alignment, range, byte enables and lane-replicated store data
    always_comb begin
        w_acc   = req_valid && req_ready;
        w_sz    = size_bytes(req_funct3);
        w_legal = req_write ? (req_funct3 <= F3_W || (W64 && req_funct3 == F3_D))
                            : (req_funct3 != 3'b111 && (W64 || (req_funct3 != F3_D && req_funct3 != F3_WU)));
        w_mis   = |(4'(req_addr[2:0]) & (w_sz - 4'd1));
        w_idx   = req_addr >> OFFW;
        w_oor   = 32'(w_idx) >= DEPTH;
        w_err   = !w_legal || w_mis || w_oor;
        w_be    = (w_acc && req_write && !w_err) ? NB'((32'd1 << w_sz) - 32'd1) << req_addr[OFFW-1:0] : '0;
        w_wdata = '0;
        for (int b = 0; b < NB; b++)
            w_wdata[8*b +: 8] = req_wdata[8*(b % int'(w_sz)) +: 8];
    end

    // load lane select and sign/zero extension from the registered raw word
    always_comb begin
        w_rsz  = size_bytes(r_f3);
        w_nb   = {w_rsz, 3'b000};
        w_lane = w_raw >> {r_off, 3'b000};
        w_low  = ~({DATA_W{1'b1}} << w_nb);
        w_top  = w_low & ~(w_low >> 1);
        w_sgn  = !r_f3[2] && |(w_lane & w_top);
        w_ext  = (w_lane & w_low) | (w_sgn ? ~w_low : '0);
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = (!req_write && !w_err) ? LOAD : RESP;
            LOAD:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state and response registers; accept clears data so stores and errors return 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_off   <= '0;
            r_f3    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_off   <= req_addr[OFFW-1:0];
                r_f3    <= req_funct3;
                r_err   <= w_err;
                r_rdata <= '0;
            end
            if (r_state == LOAD) r_rdata <= w_ext;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    dmem_be_ram #(.DATA_W(DATA_W), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
        .clk     (clk),
        .i_en    (w_acc),
        .i_addr  (w_idx[AW-1:0]),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_raw)
    );
endmodule
